// File: rtl/dcache_line_controller.sv
// D-cache line controller: sequences victim write-back and line fill over the
// per-word acknowledged L2 port, plus a flush-all walk over every set.
package dcache_line_controller_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module dcache_line_controller
  import dcache_line_controller_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 64,
  localparam int WI_W = (WORDS_PER_LINE > 2) ? $clog2(WORDS_PER_LINE) : 1,
  localparam int SS_W = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pipe_req_valid,
  input  logic              hit,
  input  logic              dirty_miss,
  input  logic              clean_miss,
  output logic              pipe_req_fulfilled,
  input  logic              flush_all_req,
  output logic              flush_all_done,
  output logic [SS_W-1:0]   scan_set,
  input  logic              scan_line_dirty,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  input  logic              l2_word_ack,
  output logic [WI_W-1:0]   word_index,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              set_new_l2_block_address,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WRITEBACK, FILL, SCAN, SCAN_WB} state_e;

  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS_PER_LINE - 1);
  localparam logic [SS_W-1:0] LAST_SET  = SS_W'(NUM_SETS - 1);

  state_e state;
  logic   xfer, word_ack, last_ack, last_set;

  assign xfer     = (state == WRITEBACK) || (state == FILL) || (state == SCAN_WB);
  assign word_ack = xfer && l2_word_ack;
  assign last_ack = word_ack && (word_index == LAST_WORD);
  assign last_set = (scan_set == LAST_SET);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_index <= '0;
      scan_set   <= '0;
    end else begin
      if (word_ack)
        word_index <= last_ack ? '0 : word_index + 1'b1;
      case (state)
        IDLE: begin
          // A pending flush-all outranks any pipeline access.
          if (flush_all_req) begin
            state    <= SCAN;
            scan_set <= '0;
          end else if (pipe_req_valid && !hit && (dirty_miss || clean_miss)) begin
            state      <= dirty_miss ? WRITEBACK : FILL;
            word_index <= '0;
          end
        end
        WRITEBACK: if (last_ack) state <= FILL;
        FILL:      if (last_ack) state <= IDLE;
        SCAN: begin
          if (scan_line_dirty) begin
            state      <= SCAN_WB;
            word_index <= '0;
          end else if (last_set) begin
            state    <= IDLE;
            scan_set <= '0;
          end else begin
            scan_set <= scan_set + 1'b1;
          end
        end
        SCAN_WB: begin
          if (last_ack) begin
            if (last_set) begin
              state    <= IDLE;
              scan_set <= '0;
            end else begin
              state    <= SCAN;
              scan_set <= scan_set + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          word_index <= '0;
          scan_set   <= '0;
        end
      endcase
    end
  end

  // Pulses coincide with the triggering ack so the datapath acts on the same word.
  always_comb begin
    pipe_req_fulfilled       = 1'b0;
    flush_all_done           = 1'b0;
    l2_req_valid             = xfer;
    l2_req_type              = LOAD;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    set_new_l2_block_address = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_all_req && pipe_req_valid) begin
          if (hit)
            pipe_req_fulfilled = 1'b1;
          else if (dirty_miss || clean_miss)
            set_new_l2_block_address = 1'b1;
        end
      end
      WRITEBACK: begin
        l2_req_type = STORE;
        flush_mode  = 1'b1;
        if (last_ack) begin
          set_new_l2_block_address = 1'b1;
          clear_selected_dirty_bit = 1'b1;
          clear_selected_valid_bit = 1'b1;
        end
      end
      FILL: begin
        load_mode = 1'b1;
        if (last_ack) finish_new_line_install = 1'b1;
      end
      SCAN: begin
        if (scan_line_dirty)
          set_new_l2_block_address = 1'b1;
        else if (last_set)
          flush_all_done = 1'b1;
      end
      SCAN_WB: begin
        l2_req_type = STORE;
        flush_mode  = 1'b1;
        if (last_ack) begin
          clear_selected_dirty_bit = 1'b1;
          flush_all_done           = last_set;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_line_controller.sv
// Directed bench for dcache_line_controller, 4 words/line and 4 sets.
module tb_dcache_line_controller;
  import dcache_line_controller_pkg::*;

  localparam int WPL = 4;
  localparam int NS  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pipe_req_valid = 0, hit = 0, dirty_miss = 0, clean_miss = 0;
  logic flush_all_req = 0, l2_word_ack = 0;
  logic pipe_req_fulfilled, flush_all_done, l2_req_valid;
  logic flush_mode, load_mode, set_new, clr_dirty, clr_valid, finish, busy;
  logic scan_line_dirty;
  logic [1:0] scan_set;
  logic [1:0] word_index;
  memory_operation_e l2_req_type;
  logic [NS-1:0] dirty_map = '0;

  int n_tests = 0, n_fail = 0;
  int n_fin = 0, n_clrd = 0, n_clrv = 0, n_done = 0;

  always #5 clk = ~clk;

  // Array model: dirty bit of the addressed set.
  assign scan_line_dirty = dirty_map[scan_set];

  dcache_line_controller #(.WORDS_PER_LINE(WPL), .NUM_SETS(NS)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_req_valid(pipe_req_valid), .hit(hit), .dirty_miss(dirty_miss),
    .clean_miss(clean_miss), .pipe_req_fulfilled(pipe_req_fulfilled),
    .flush_all_req(flush_all_req), .flush_all_done(flush_all_done),
    .scan_set(scan_set), .scan_line_dirty(scan_line_dirty),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type),
    .l2_word_ack(l2_word_ack), .word_index(word_index),
    .flush_mode(flush_mode), .load_mode(load_mode),
    .set_new_l2_block_address(set_new),
    .clear_selected_dirty_bit(clr_dirty), .clear_selected_valid_bit(clr_valid),
    .finish_new_line_install(finish), .busy(busy)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      n_fin  += int'(finish);
      n_clrd += int'(clr_dirty);
      n_clrv += int'(clr_valid);
      n_done += int'(flush_all_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fin0, clrd0, clrv0, done0, k;
    logic seen;

    // Reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_wi", word_index, 0);
    chk("rst_scan", scan_set, 0);
    chk("rst_l2v", l2_req_valid, 0);
    chk("rst_type", l2_req_type, LOAD);
    chk("rst_pulses", {pipe_req_fulfilled, flush_all_done, set_new, clr_dirty,
                       clr_valid, finish, flush_mode, load_mode}, 0);
    cyc(); cyc();
    reset_n = 1;

    // Hit, then hit + dirty_miss
    pipe_req_valid = 1; hit = 1; #2;
    chk("hit_fulfilled", pipe_req_fulfilled, 1);
    chk("hit_l2v", l2_req_valid, 0);
    chk("hit_setaddr", set_new, 0);
    cyc();
    dirty_miss = 1; #2;
    chk("hitdm_fulfilled", pipe_req_fulfilled, 1);
    chk("hitdm_setaddr", set_new, 0);
    cyc();
    chk("hitdm_busy", busy, 0);
    pipe_req_valid = 0; hit = 0; dirty_miss = 0;

    // Ack without a request is ignored
    l2_word_ack = 1; cyc(); cyc(); l2_word_ack = 0; #2;
    chk("stray_ack_wi", word_index, 0);
    chk("stray_ack_busy", busy, 0);
    cyc();

    // Clean miss, ack every cycle
    fin0 = n_fin;
    pipe_req_valid = 1; clean_miss = 1; #2;
    chk("cm_setaddr", set_new, 1);
    chk("cm_fulfilled", pipe_req_fulfilled, 0);
    cyc();
    pipe_req_valid = 0; clean_miss = 0;
    for (int i = 0; i < WPL; i++) begin
      l2_word_ack = 1; #2;
      chk("fill_l2v", l2_req_valid, 1);
      chk("fill_type", l2_req_type, LOAD);
      chk("fill_load_mode", load_mode, 1);
      chk("fill_wi", word_index, i);
      chk("fill_finish", finish, i == WPL-1);
      chk("fill_fulfilled", pipe_req_fulfilled, 0);
      cyc();
    end
    l2_word_ack = 0; #2;
    chk("fill_idle", busy, 0);
    chk("fill_fin_count", n_fin - fin0, 1);
    cyc();

    // Dirty miss, acks on cycles 1,3,4,7, then fill
    clrd0 = n_clrd; clrv0 = n_clrv;
    pipe_req_valid = 1; dirty_miss = 1; #2;
    chk("dm_setaddr", set_new, 1);
    cyc();
    pipe_req_valid = 0; dirty_miss = 0;
    k = 0;
    for (int c = 1; c <= 7; c++) begin
      l2_word_ack = (c == 1 || c == 3 || c == 4 || c == 7);
      #2;
      chk("wb_type", l2_req_type, STORE);
      chk("wb_flush_mode", flush_mode, 1);
      chk("wb_wi", word_index, k);
      chk("wb_clrd", clr_dirty, c == 7);
      chk("wb_clrv", clr_valid, c == 7);
      chk("wb_setaddr", set_new, c == 7);
      if (l2_word_ack) k++;
      cyc();
    end
    for (int i = 0; i < WPL; i++) begin
      l2_word_ack = 1; #2;
      chk("wbfill_type", l2_req_type, LOAD);
      chk("wbfill_wi", word_index, i);
      chk("wbfill_finish", finish, i == WPL-1);
      cyc();
    end
    l2_word_ack = 0; #2;
    chk("wbfill_idle", busy, 0);
    chk("wb_clrd_count", n_clrd - clrd0, 1);
    chk("wb_clrv_count", n_clrv - clrv0, 1);
    cyc();

    // Reset in the middle of a fill
    pipe_req_valid = 1; clean_miss = 1; cyc();
    pipe_req_valid = 0; clean_miss = 0;
    l2_word_ack = 1; cyc(); cyc(); l2_word_ack = 0; #2;
    chk("midrst_pre_wi", word_index, 2);
    fin0 = n_fin;
    reset_n = 0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wi", word_index, 0);
    chk("midrst_finish", finish, 0);
    chk("midrst_l2v", l2_req_valid, 0);
    cyc(); reset_n = 1; cyc();
    chk("midrst_fin_count", n_fin - fin0, 0);
    chk("midrst_idle", busy, 0);

    // Flush-all, dirty sets {1,3}
    clrd0 = n_clrd; clrv0 = n_clrv; done0 = n_done;
    dirty_map = 4'b1010;
    flush_all_req = 1; #2;
    chk("fa_idle", busy, 0);
    cyc(); #2;
    chk("fa_s0_set", scan_set, 0);
    chk("fa_s0_busy", busy, 1);
    chk("fa_s0_setaddr", set_new, 0);
    cyc(); #2;
    chk("fa_s1_set", scan_set, 1);
    chk("fa_s1_setaddr", set_new, 1);
    cyc();
    for (int i = 0; i < WPL; i++) begin
      l2_word_ack = 1; #2;
      chk("fa_wb1_type", l2_req_type, STORE);
      chk("fa_wb1_wi", word_index, i);
      chk("fa_wb1_clrd", clr_dirty, i == WPL-1);
      chk("fa_wb1_done", flush_all_done, 0);
      cyc();
    end
    l2_word_ack = 0; #2;
    chk("fa_s2_set", scan_set, 2);
    chk("fa_s2_l2v", l2_req_valid, 0);
    chk("fa_s2_setaddr", set_new, 0);
    cyc(); #2;
    chk("fa_s3_set", scan_set, 3);
    chk("fa_s3_setaddr", set_new, 1);
    cyc();
    for (int i = 0; i < WPL; i++) begin
      l2_word_ack = 1; #2;
      chk("fa_wb3_wi", word_index, i);
      chk("fa_wb3_done", flush_all_done, i == WPL-1);
      if (flush_all_done) flush_all_req = 0;
      cyc();
    end
    l2_word_ack = 0; flush_all_req = 0; #2;
    chk("fa_end_busy", busy, 0);
    chk("fa_end_scan", scan_set, 0);
    chk("fa_clrd_count", n_clrd - clrd0, 2);
    chk("fa_clrv_count", n_clrv - clrv0, 0);
    chk("fa_done_count", n_done - done0, 1);
    cyc();

    // Flush-all latency with no dirty lines
    dirty_map = '0;
    flush_all_req = 1; cyc();
    for (int i = 1; i <= NS; i++) begin
      #2;
      chk("lat_done", flush_all_done, i == NS);
      if (flush_all_done) flush_all_req = 0;
      cyc();
    end
    flush_all_req = 0; #2;
    chk("lat_idle", busy, 0);
    cyc();

    // Flush request raised during a fill
    fin0 = n_fin;
    pipe_req_valid = 1; clean_miss = 1; cyc();
    pipe_req_valid = 0; clean_miss = 0;
    l2_word_ack = 1; cyc();
    flush_all_req = 1;
    for (int i = 1; i < WPL; i++) begin
      #2;
      chk("ff_load_mode", load_mode, 1);
      chk("ff_wi", word_index, i);
      cyc();
    end
    l2_word_ack = 0; #2;
    chk("ff_fin_count", n_fin - fin0, 1);
    chk("ff_idle", busy, 0);
    chk("ff_idle_setaddr", set_new, 0);
    cyc(); #2;
    chk("ff_scan_busy", busy, 1);
    chk("ff_scan_set", scan_set, 0);
    chk("ff_scan_l2v", l2_req_valid, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (flush_all_done) begin
        seen = 1;
        flush_all_req = 0;
      end
      cyc(); #2;
    end
    chk("ff_done_seen", seen, 1);
    flush_all_req = 0;
    chk("ff_end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
